mc_controller: RTL and testbench
================================

# mc_controller

Multicycle control unit for the 32-bit ARM-subset CPU, successor to the single-cycle controller. It sequences each instruction through a state machine (fetch, decode, execute, memory, writeback) and evaluates conditions against a registered NZCV flag file. It drives the shared-memory multicycle datapath and optionally stalls on a memory-ready handshake. It is parametrised for an extended ALU-op set (EOR, CMP, TST).

## Interface
- `EXT_OPS`, default 0. When 1, decode EOR, CMP and TST. When 0, those opcodes decode as ADD with RegWrite suppressed.
- `MEM_WAIT`, default 0. When 1, FETCH, MEMRD and MEMWR wait for `MemReady`. When 0, `MemReady` is ignored and treated as 1.
- `clk`, in, 1: single clock, rising edge.
- `reset`, in, 1: asynchronous, active-low (0 = reset).
- `Instr`, in, 20 (`[31:12]`): instruction register contents.
- `ALUFlags`, in, 4: N,Z,C,V from the ALU in the current cycle.
- `MemReady`, in, 1: memory access completes this cycle.
- `PCWrite`, `IRWrite`, `RegWrite`, `MemWrite`, out, 1 each: write enables.
- `AdrSrc`, out, 1: memory address select (0 = PC, 1 = ALU result register).
- `ALUSrcA`, out, 1: ALU A select (0 = Rn, 1 = PC).
- `ALUSrcB`, out, 2: ALU B select (00 = Rm, 01 = ExtImm, 10 = constant 4).
- `ResultSrc`, out, 2: result select (00 = ALUOut, 01 = read data, 10 = ALU direct).
- `RegSrc`, out, 2: bit0 = branch (read R15), bit1 = store (read Rd).
- `ImmSrc`, out, 2: equals `Instr[27:26]`.
- `ALUControl`, out, 3: 000 ADD, 001 SUB, 010 AND, 011 ORR, 100 EOR.
- `Illegal`, out, 1: sticky undefined-instruction indicator.

## Operation
- **States:** FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, BRANCH, UNKNOWN.
- **FETCH:**
  - Drives AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ADD, ResultSrc=10.
  - When ready, asserts IRWrite=1 and PCWrite=1 and moves to DECODE.
  - While not ready, IRWrite and PCWrite are 0 and the state holds.
- **DECODE:**
  - Drives ALUSrcA=1, ALUSrcB=10, ResultSrc=10.
  - Latches CondEx into `cond_q`.
  - Next state by Op: 01 → MEMADR; 00 with I=`Instr[25]`=1 → EXECI; 00 with I=0 → EXECR; 10 → BRANCH; 11 → UNKNOWN.
- **MEMADR:** ALUSrcA=0, ALUSrcB=01, ADD. Next state is MEMRD if L=`Instr[20]`=1, else MEMWR.
- **MEMRD:** AdrSrc=1. Moves to MEMWB when ready.
- **MEMWB:** ResultSrc=01, RegWrite=`cond_q`. Moves to FETCH.
- **MEMWR:** AdrSrc=1, MemWrite=`cond_q`, held high until ready. Then moves to FETCH.
- **EXECR / EXECI:** ALUSrcA=0, ALUSrcB=00 (EXECR) or 01 (EXECI). ALUControl from cmd=`Instr[24:21]`. Moves to ALUWB.
- **ALUWB:** ResultSrc=00, RegWrite=`cond_q` & ~NoWrite. Moves to FETCH.
- **BRANCH:** ALUSrcA=0, ALUSrcB=01, ADD, ResultSrc=10, PCWrite=`cond_q`. Moves to FETCH.
- **Writes to R15:** if Rd=`Instr[15:12]`=15 in MEMWB or ALUWB, PCWrite=`cond_q` (& ~NoWrite in ALUWB) alongside RegWrite.
- **UNKNOWN:** all enables 0, `Illegal`=1. Held until reset.
- **Command decode:**
  - 0100 → ADD.
  - 0010 → SUB.
  - 0000 → AND.
  - 1100 → ORR.
  - EXT_OPS=1 adds: 0001 → EOR; 1010 → SUB with NoWrite (CMP); 1000 → AND with NoWrite (TST).
  - Any other cmd → ADD with NoWrite.
- **FlagW:**
  - Applies only in EXECR/EXECI, and only when S=`Instr[20]`=1.
  - ADD/SUB (including CMP) → 11.
  - AND/ORR/EOR/TST → 10.
  - FlagW is 00 in every other state.
- **Flag register update:** at the clock edge, NZ ← ALUFlags[3:2] if FlagW[1] & `cond_q`; CV ← ALUFlags[1:0] if FlagW[0] & `cond_q`.
- **CondEx** is computed from `Instr[31:28]` and the registered flags:
  - EQ, NE, CS, CC, MI, PL, VS, VC, HI, LS, GE, LT, GT, LE follow standard ARM semantics.
  - 1110 (AL) → 1.
  - 1111 → 0.

## Timing
- **Reset (`reset`=0):**
  - Asynchronously forces state=FETCH, flags=0000, `cond_q`=0, `Illegal`=0.
  - All write enables are 0 while reset is low.
  - Other outputs take their FETCH values.
- **Outputs** are Moore decodes of state, with `cond_q`, `Instr` and `MemReady` gating only the enables.
- **Latency with MemReady=1:**
  - Data-processing: 4 cycles.
  - LDR: 5 cycles.
  - STR: 4 cycles.
  - Branch: 3 cycles.
- **Wait states:** each cycle with MemReady=0 in FETCH, MEMRD or MEMWR adds one cycle. No enable pulses twice.
- **Flag timing:** flags change on the edge ending EXECR/EXECI and are visible to the next instruction's DECODE.
- **Reset mid-instruction:** outstanding MemWrite and RegWrite drop immediately. No partial write completes after reset rises.

## Test plan
- **ADDS R1,R2,R3 (AL), ALUFlags=0100:** states FETCH, DECODE, EXECR, ALUWB. RegWrite=1 in cycle 4 only. Flags=0100 after cycle 3.
- **MEM_WAIT=1, LDR with MemReady low for 2 cycles in MEMRD:** MEMRD lasts 3 cycles. RegWrite pulses once in MEMWB with ResultSrc=01.
- **BEQ with Z=0, then BEQ after a SUBS giving Z=1:** PCWrite=0 in the first BRANCH; PCWrite=1 in the second.
- **EXT_OPS=1, CMP R1,#5 with ALUFlags=0110:** RegWrite stays 0. Flags become 0110. ALUControl=001.
- **Reset pulsed low during MEMWR with MemReady=0:** MemWrite falls within the same cycle. State=FETCH and flags=0 on release.
- **Op=11:** UNKNOWN is entered. `Illegal`=1 and all enables stay 0 for 10 or more cycles until reset.

Source files
------------

// File: rtl/mc_controller_if.sv
// Controller <-> datapath bundle for the multicycle ARM-subset CPU.
// The controller sits on the master side, the datapath on the slave side.
interface mc_controller_if;
    logic [31:12] Instr;
    logic [3:0]   ALUFlags;
    logic         MemReady;

    logic         PCWrite;
    logic         IRWrite;
    logic         RegWrite;
    logic         MemWrite;
    logic         AdrSrc;
    logic         ALUSrcA;
    logic [1:0]   ALUSrcB;
    logic [1:0]   ResultSrc;
    logic [1:0]   RegSrc;
    logic [1:0]   ImmSrc;
    logic [2:0]   ALUControl;
    logic         Illegal;

    modport master (
        input  Instr, ALUFlags, MemReady,
        output PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc, ALUSrcA, ALUSrcB,
               ResultSrc, RegSrc, ImmSrc, ALUControl, Illegal
    );

    modport slave (
        output Instr, ALUFlags, MemReady,
        input  PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc, ALUSrcA, ALUSrcB,
               ResultSrc, RegSrc, ImmSrc, ALUControl, Illegal
    );
endinterface

// File: rtl/mc_controller.sv
// Multicycle control unit: sequences fetch/decode/execute/memory/writeback,
// evaluates ARM condition codes against a registered NZCV flag file.
module mc_controller #(
    parameter bit EXT_OPS  = 1'b0,
    parameter bit MEM_WAIT = 1'b0
) (
    input logic            clk,
    input logic            reset,
    mc_controller_if.master bus
);

    typedef enum logic [3:0] {
        StFetch   = 4'd0,
        StDecode  = 4'd1,
        StMemAdr  = 4'd2,
        StMemRd   = 4'd3,
        StMemWb   = 4'd4,
        StMemWr   = 4'd5,
        StExecR   = 4'd6,
        StExecI   = 4'd7,
        StAluWb   = 4'd8,
        StBranch  = 4'd9,
        StUnknown = 4'd10
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] flags_q, flags_d;
    logic       cond_q, cond_d;
    logic       illegal_q, illegal_d;

    logic [3:0] cond;
    logic [1:0] op;
    logic       i_bit;
    logic [3:0] cmd;
    logic       s_bit;
    logic       rd_pc;
    logic       ready;
    logic       unused_rn;

    assign cond  = bus.Instr[31:28];
    assign op    = bus.Instr[27:26];
    assign i_bit = bus.Instr[25];
    assign cmd   = bus.Instr[24:21];
    assign s_bit = bus.Instr[20];
    assign rd_pc = (bus.Instr[15:12] == 4'hF);
    assign ready = MEM_WAIT ? bus.MemReady : 1'b1;
    assign unused_rn = ^bus.Instr[19:16];

    logic [2:0] dp_alu;
    logic       dp_logic;
    logic       no_write;

    // Data-processing command decode; unrecognised commands become a silent ADD.
    always_comb begin
        dp_alu   = 3'b000;
        dp_logic = 1'b0;
        no_write = 1'b0;
        case (cmd)
            4'b0100: dp_alu = 3'b000;
            4'b0010: dp_alu = 3'b001;
            4'b0000: begin dp_alu = 3'b010; dp_logic = 1'b1; end
            4'b1100: begin dp_alu = 3'b011; dp_logic = 1'b1; end
            4'b0001: begin
                if (EXT_OPS) begin dp_alu = 3'b100; dp_logic = 1'b1; end
                else no_write = 1'b1;
            end
            4'b1010: begin
                no_write = 1'b1;
                if (EXT_OPS) dp_alu = 3'b001;
            end
            4'b1000: begin
                no_write = 1'b1;
                if (EXT_OPS) begin dp_alu = 3'b010; dp_logic = 1'b1; end
            end
            default: no_write = 1'b1;
        endcase
    end

    logic flag_n, flag_z, flag_c, flag_v;
    logic cond_ex;
    assign {flag_n, flag_z, flag_c, flag_v} = flags_q;

    // Condition evaluation against the registered flags.
    always_comb begin
        cond_ex = 1'b0;
        case (cond)
            4'b0000: cond_ex = flag_z;
            4'b0001: cond_ex = ~flag_z;
            4'b0010: cond_ex = flag_c;
            4'b0011: cond_ex = ~flag_c;
            4'b0100: cond_ex = flag_n;
            4'b0101: cond_ex = ~flag_n;
            4'b0110: cond_ex = flag_v;
            4'b0111: cond_ex = ~flag_v;
            4'b1000: cond_ex = flag_c & ~flag_z;
            4'b1001: cond_ex = ~(flag_c & ~flag_z);
            4'b1010: cond_ex = (flag_n == flag_v);
            4'b1011: cond_ex = (flag_n != flag_v);
            4'b1100: cond_ex = ~flag_z & (flag_n == flag_v);
            4'b1101: cond_ex = flag_z | (flag_n != flag_v);
            4'b1110: cond_ex = 1'b1;
            default: cond_ex = 1'b0;
        endcase
    end

    logic       pc_write, ir_write, reg_write, mem_write;
    logic       adr_src, alu_src_a;
    logic [1:0] alu_src_b, result_src, flag_w;
    logic [2:0] alu_control;

    // Next-state and Moore datapath controls; enables are gated by cond_q/ready.
    always_comb begin
        state_d     = state_q;
        pc_write    = 1'b0;
        ir_write    = 1'b0;
        reg_write   = 1'b0;
        mem_write   = 1'b0;
        adr_src     = 1'b0;
        alu_src_a   = 1'b0;
        alu_src_b   = 2'b00;
        result_src  = 2'b00;
        alu_control = 3'b000;
        flag_w      = 2'b00;
        unique case (state_q)
            StFetch: begin
                alu_src_a  = 1'b1;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                if (ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = StDecode;
                end
            end
            StDecode: begin
                alu_src_a  = 1'b1;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                case (op)
                    2'b01:   state_d = StMemAdr;
                    2'b00:   state_d = i_bit ? StExecI : StExecR;
                    2'b10:   state_d = StBranch;
                    default: state_d = StUnknown;
                endcase
            end
            StMemAdr: begin
                alu_src_b = 2'b01;
                state_d   = s_bit ? StMemRd : StMemWr;
            end
            StMemRd: begin
                adr_src = 1'b1;
                if (ready) state_d = StMemWb;
            end
            StMemWb: begin
                result_src = 2'b01;
                reg_write  = cond_q;
                pc_write   = cond_q & rd_pc;
                state_d    = StFetch;
            end
            StMemWr: begin
                adr_src   = 1'b1;
                mem_write = cond_q;
                if (ready) state_d = StFetch;
            end
            StExecR, StExecI: begin
                alu_src_b   = (state_q == StExecI) ? 2'b01 : 2'b00;
                alu_control = dp_alu;
                if (s_bit) flag_w = dp_logic ? 2'b10 : 2'b11;
                state_d     = StAluWb;
            end
            StAluWb: begin
                reg_write = cond_q & ~no_write;
                pc_write  = cond_q & ~no_write & rd_pc;
                state_d   = StFetch;
            end
            StBranch: begin
                alu_src_b  = 2'b01;
                result_src = 2'b10;
                pc_write   = cond_q;
                state_d    = StFetch;
            end
            StUnknown: state_d = StUnknown;
            default:   state_d = StFetch;
        endcase
    end

    // Flag file, condition latch and sticky illegal indicator next-state.
    always_comb begin
        flags_d = flags_q;
        if (flag_w[1] & cond_q) flags_d[3:2] = bus.ALUFlags[3:2];
        if (flag_w[0] & cond_q) flags_d[1:0] = bus.ALUFlags[1:0];
        cond_d    = (state_q == StDecode) ? cond_ex : cond_q;
        illegal_d = illegal_q | (state_d == StUnknown);
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= StFetch;
            flags_q   <= 4'b0000;
            cond_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            flags_q   <= flags_d;
            cond_q    <= cond_d;
            illegal_q <= illegal_d;
        end
    end

    // Enables are forced low while reset is held so nothing writes mid-reset.
    assign bus.PCWrite    = reset & pc_write;
    assign bus.IRWrite    = reset & ir_write;
    assign bus.RegWrite   = reset & reg_write;
    assign bus.MemWrite   = reset & mem_write;
    assign bus.AdrSrc     = adr_src;
    assign bus.ALUSrcA    = alu_src_a;
    assign bus.ALUSrcB    = alu_src_b;
    assign bus.ResultSrc  = result_src;
    assign bus.ALUControl = alu_control;
    assign bus.RegSrc     = {(op == 2'b01) & ~s_bit, (op == 2'b10)};
    assign bus.ImmSrc     = op;
    assign bus.Illegal    = illegal_q;

endmodule

// File: tb/tb_mc_controller.sv
// Directed scoreboard bench for mc_controller (EXT_OPS=1, MEM_WAIT=1).
module tb_mc_controller;

    logic clk = 1'b0;
    logic reset;

    mc_controller_if bus ();

    mc_controller #(
        .EXT_OPS  (1'b1),
        .MEM_WAIT (1'b1)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Control vector: {PCW, IRW, RW, MW, AdrSrc, SrcA, SrcB[2], ResSrc[2], ALUCtl[3], Illegal}
    localparam logic [13:0] C_FETCH  = {4'b1100, 1'b0, 1'b1, 2'b10, 2'b10, 3'b000, 1'b0};
    localparam logic [13:0] C_FWAIT  = {4'b0000, 1'b0, 1'b1, 2'b10, 2'b10, 3'b000, 1'b0};
    localparam logic [13:0] C_DEC    = {4'b0000, 1'b0, 1'b1, 2'b10, 2'b10, 3'b000, 1'b0};
    localparam logic [13:0] C_XR_ADD = {4'b0000, 1'b0, 1'b0, 2'b00, 2'b00, 3'b000, 1'b0};
    localparam logic [13:0] C_XR_SUB = {4'b0000, 1'b0, 1'b0, 2'b00, 2'b00, 3'b001, 1'b0};
    localparam logic [13:0] C_XR_EOR = {4'b0000, 1'b0, 1'b0, 2'b00, 2'b00, 3'b100, 1'b0};
    localparam logic [13:0] C_XI_SUB = {4'b0000, 1'b0, 1'b0, 2'b01, 2'b00, 3'b001, 1'b0};
    localparam logic [13:0] C_WB_W   = {4'b0010, 1'b0, 1'b0, 2'b00, 2'b00, 3'b000, 1'b0};
    localparam logic [13:0] C_WB_NW  = {4'b0000, 1'b0, 1'b0, 2'b00, 2'b00, 3'b000, 1'b0};
    localparam logic [13:0] C_WB_PC  = {4'b1010, 1'b0, 1'b0, 2'b00, 2'b00, 3'b000, 1'b0};
    localparam logic [13:0] C_MADR   = {4'b0000, 1'b0, 1'b0, 2'b01, 2'b00, 3'b000, 1'b0};
    localparam logic [13:0] C_MRD    = {4'b0000, 1'b1, 1'b0, 2'b00, 2'b00, 3'b000, 1'b0};
    localparam logic [13:0] C_MWB    = {4'b0010, 1'b0, 1'b0, 2'b00, 2'b01, 3'b000, 1'b0};
    localparam logic [13:0] C_MWR    = {4'b0001, 1'b1, 1'b0, 2'b00, 2'b00, 3'b000, 1'b0};
    localparam logic [13:0] C_BR_T   = {4'b1000, 1'b0, 1'b0, 2'b01, 2'b10, 3'b000, 1'b0};
    localparam logic [13:0] C_BR_N   = {4'b0000, 1'b0, 1'b0, 2'b01, 2'b10, 3'b000, 1'b0};
    localparam logic [13:0] C_UNK    = {4'b0000, 1'b0, 1'b0, 2'b00, 2'b00, 3'b000, 1'b1};

    // Care masks: only fields the state actually defines are compared.
    localparam logic [13:0] M_ALL  = 14'h3FFF;
    localparam logic [13:0] M_DEC  = 14'h3DF1;
    localparam logic [13:0] M_EXEC = 14'h3DCF;
    localparam logic [13:0] M_WB   = 14'h3C31;
    localparam logic [13:0] M_MEM  = 14'h3E01;
    localparam logic [13:0] M_BR   = 14'h3DFF;
    localparam logic [13:0] M_UNK  = 14'h3C01;

    localparam logic [3:0] S_FETCH = 4'd0, S_DEC = 4'd1, S_MADR = 4'd2, S_MRD = 4'd3;
    localparam logic [3:0] S_MWB = 4'd4, S_MWR = 4'd5, S_XR = 4'd6, S_XI = 4'd7;
    localparam logic [3:0] S_WB = 4'd8, S_BR = 4'd9, S_UNK = 4'd10;

    typedef struct {
        string       tag;
        int          kind;  // 0 = control vector, 1 = state, 2 = flags
        logic [31:0] exp;
        logic [31:0] mask;
    } item_t;

    item_t sb[$];
    int    n_tests = 0;
    int    n_fail  = 0;

    function automatic logic [31:0] observe(int kind);
        case (kind)
            0: return {18'b0, bus.PCWrite, bus.IRWrite, bus.RegWrite, bus.MemWrite,
                       bus.AdrSrc, bus.ALUSrcA, bus.ALUSrcB, bus.ResultSrc,
                       bus.ALUControl, bus.Illegal};
            1: return 32'(dut.state_q);
            default: return {28'b0, dut.flags_q};
        endcase
    endfunction

    function automatic logic [19:0] mk(logic [3:0] c, logic [1:0] o, logic i, logic [3:0] cm,
                                       logic s, logic [3:0] rn, logic [3:0] rd);
        return {c, o, i, cm, s, rn, rd};
    endfunction

    task automatic push(string tag, int kind, logic [31:0] exp, logic [31:0] mask);
        item_t it;
        it.tag  = tag;
        it.kind = kind;
        it.exp  = exp;
        it.mask = mask;
        sb.push_back(it);
    endtask

    task automatic drain();
        while (sb.size() > 0) begin
            item_t       it;
            logic [31:0] obs;
            it  = sb.pop_front();
            obs = observe(it.kind);
            n_tests++;
            assert ((obs & it.mask) === (it.exp & it.mask))
            else begin
                n_fail++;
                $error("FAIL %s: observed %h expected %h (mask %h)",
                       it.tag, obs, it.exp, it.mask);
            end
        end
    endtask

    task automatic push_flags(string tag, logic [3:0] f);
        push(tag, 2, {28'b0, f}, 32'hF);
    endtask

    // One clock: queue control/state expectations, compare mid-cycle, advance.
    task automatic step(string tag, logic [13:0] c, logic [13:0] m, logic [3:0] s);
        push(tag, 0, {18'b0, c}, {18'b0, m});
        push({tag, "_state"}, 1, {28'b0, s}, 32'hF);
        @(negedge clk);
        drain();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset        = 1'b0;
        bus.Instr    = '0;
        bus.ALUFlags = 4'b0000;
        bus.MemReady = 1'b1;
        @(posedge clk);
        #1;
        push("reset_ctrl", 0, {18'b0, C_FWAIT}, {18'b0, M_ALL});
        push("reset_state", 1, {28'b0, S_FETCH}, 32'hF);
        push_flags("reset_flags", 4'b0000);
        @(negedge clk);
        drain();
        @(posedge clk);
        #1;
        reset = 1'b1;

        // BEQ with Z=0: not taken
        bus.Instr = mk(4'b0000, 2'b10, 1'b0, 4'b0000, 1'b0, 4'd0, 4'd0);
        step("beq0_fetch", C_FETCH, M_ALL, S_FETCH);
        step("beq0_dec", C_DEC, M_DEC, S_DEC);
        step("beq0_branch", C_BR_N, M_BR, S_BR);

        // ADDS R1,R2,R3 with ALUFlags=0100
        bus.ALUFlags = 4'b0100;
        bus.Instr = mk(4'b1110, 2'b00, 1'b0, 4'b0100, 1'b1, 4'd2, 4'd1);
        step("adds_fetch", C_FETCH, M_ALL, S_FETCH);
        step("adds_dec", C_DEC, M_DEC, S_DEC);
        push_flags("adds_flags_pre", 4'b0000);
        step("adds_exec", C_XR_ADD, M_EXEC, S_XR);
        push_flags("adds_flags", 4'b0100);
        step("adds_wb", C_WB_W, M_WB, S_WB);

        // SUBS giving Z=1, V=1
        bus.ALUFlags = 4'b0101;
        bus.Instr = mk(4'b1110, 2'b00, 1'b0, 4'b0010, 1'b1, 4'd2, 4'd1);
        step("subs_fetch", C_FETCH, M_ALL, S_FETCH);
        step("subs_dec", C_DEC, M_DEC, S_DEC);
        step("subs_exec", C_XR_SUB, M_EXEC, S_XR);
        push_flags("subs_flags", 4'b0101);
        step("subs_wb", C_WB_W, M_WB, S_WB);

        // BEQ with Z=1: taken
        bus.Instr = mk(4'b0000, 2'b10, 1'b0, 4'b0000, 1'b0, 4'd0, 4'd0);
        step("beq1_fetch", C_FETCH, M_ALL, S_FETCH);
        step("beq1_dec", C_DEC, M_DEC, S_DEC);
        step("beq1_branch", C_BR_T, M_BR, S_BR);

        // LDR with two wait cycles in MEMRD
        bus.Instr = mk(4'b1110, 2'b01, 1'b0, 4'b1100, 1'b1, 4'd2, 4'd1);
        step("ldr_fetch", C_FETCH, M_ALL, S_FETCH);
        step("ldr_dec", C_DEC, M_DEC, S_DEC);
        step("ldr_madr", C_MADR, M_EXEC, S_MADR);
        bus.MemReady = 1'b0;
        step("ldr_memrd_w1", C_MRD, M_MEM, S_MRD);
        step("ldr_memrd_w2", C_MRD, M_MEM, S_MRD);
        bus.MemReady = 1'b1;
        step("ldr_memrd_go", C_MRD, M_MEM, S_MRD);
        step("ldr_memwb", C_MWB, M_WB, S_MWB);

        // CMP R1,#5 with ALUFlags=0110
        bus.ALUFlags = 4'b0110;
        bus.Instr = mk(4'b1110, 2'b00, 1'b1, 4'b1010, 1'b1, 4'd1, 4'd0);
        step("cmp_fetch", C_FETCH, M_ALL, S_FETCH);
        step("cmp_dec", C_DEC, M_DEC, S_DEC);
        step("cmp_exec", C_XI_SUB, M_EXEC, S_XI);
        push_flags("cmp_flags", 4'b0110);
        step("cmp_wb", C_WB_NW, M_WB, S_WB);

        // ADDSNE with Z=1: condition fails, no write, flags kept
        bus.ALUFlags = 4'b1000;
        bus.Instr = mk(4'b0001, 2'b00, 1'b0, 4'b0100, 1'b1, 4'd2, 4'd1);
        step("addne_fetch", C_FETCH, M_ALL, S_FETCH);
        step("addne_dec", C_DEC, M_DEC, S_DEC);
        step("addne_exec", C_XR_ADD, M_EXEC, S_XR);
        push_flags("addne_flags", 4'b0110);
        step("addne_wb", C_WB_NW, M_WB, S_WB);

        // EOR R1,R2,R3
        bus.Instr = mk(4'b1110, 2'b00, 1'b0, 4'b0001, 1'b0, 4'd2, 4'd1);
        step("eor_fetch", C_FETCH, M_ALL, S_FETCH);
        step("eor_dec", C_DEC, M_DEC, S_DEC);
        step("eor_exec", C_XR_EOR, M_EXEC, S_XR);
        step("eor_wb", C_WB_W, M_WB, S_WB);

        // ADD R15,R1,R2: write to PC
        bus.Instr = mk(4'b1110, 2'b00, 1'b0, 4'b0100, 1'b0, 4'd1, 4'd15);
        step("addpc_fetch", C_FETCH, M_ALL, S_FETCH);
        step("addpc_dec", C_DEC, M_DEC, S_DEC);
        step("addpc_exec", C_XR_ADD, M_EXEC, S_XR);
        step("addpc_wb", C_WB_PC, M_WB, S_WB);

        // STR with fetch wait, then reset while MEMWR is stalled
        bus.Instr = mk(4'b1110, 2'b01, 1'b0, 4'b1100, 1'b0, 4'd2, 4'd1);
        bus.MemReady = 1'b0;
        step("str_fetch_wait", C_FWAIT, M_ALL, S_FETCH);
        bus.MemReady = 1'b1;
        step("str_fetch", C_FETCH, M_ALL, S_FETCH);
        step("str_dec", C_DEC, M_DEC, S_DEC);
        step("str_madr", C_MADR, M_EXEC, S_MADR);
        bus.MemReady = 1'b0;
        step("str_memwr_w1", C_MWR, M_MEM, S_MWR);
        step("str_memwr_w2", C_MWR, M_MEM, S_MWR);
        #2;
        reset = 1'b0;
        #1;
        push("rst_mid_ctrl", 0, {18'b0, C_FWAIT}, {18'b0, M_ALL});
        push("rst_mid_state", 1, {28'b0, S_FETCH}, 32'hF);
        push_flags("rst_mid_flags", 4'b0000);
        drain();
        @(posedge clk);
        #1;
        reset = 1'b1;
        bus.MemReady = 1'b1;
        push_flags("post_rst_flags", 4'b0000);
        step("str2_fetch", C_FETCH, M_ALL, S_FETCH);
        step("str2_dec", C_DEC, M_DEC, S_DEC);
        step("str2_madr", C_MADR, M_EXEC, S_MADR);
        step("str2_memwr", C_MWR, M_MEM, S_MWR);

        // Op=11: undefined instruction, held until reset
        bus.Instr = mk(4'b1110, 2'b11, 1'b0, 4'b0100, 1'b1, 4'd2, 4'd15);
        step("unk_fetch", C_FETCH, M_ALL, S_FETCH);
        step("unk_dec", C_DEC, M_DEC, S_DEC);
        for (int k = 0; k < 12; k++) begin
            bus.MemReady = k[0];
            step($sformatf("unk_hold%0d", k), C_UNK, M_UNK, S_UNK);
        end
        reset = 1'b0;
        #1;
        push("unk_reset_ctrl", 0, {18'b0, C_FWAIT}, {18'b0, M_ALL});
        push("unk_reset_state", 1, {28'b0, S_FETCH}, 32'hF);
        drain();
        @(posedge clk);
        #1;
        reset = 1'b1;
        bus.MemReady = 1'b1;
        step("after_unk_fetch", C_FETCH, M_ALL, S_FETCH);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
